// File: rtl/uart_rx_byte_fifo.sv
// UART receiver (8N1) feeding a small show-ahead byte FIFO.
// RxD is synchronised, deserialised LSB first at mid-bit, and accepted bytes are
// presented on a valid/ready port with a one-cycle isNewData pulse per write.
// Optional: define UART_RX_PARITY_EN for 8E1 framing with a sticky parity_err output.
module uart_rx_byte_fifo #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       isNewData,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  input  logic       err_clr
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = PtrW + 1;

  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            meta_q, rxs_q, rxs_prev_q;
  logic            fall;
  logic            push_req, frame_set;
  logic            par_bad_q, par_bad_d, par_set;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] count_q, count_d;
  logic            full, pop, push_ok, over_set;
  logic            new_q;
  logic            frame_err_q, overrun_q, parity_err_q;

  // Two-flop synchroniser plus one history flop for start-edge detection; idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      meta_q     <= RxD;
      rxs_q      <= meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Only a genuine high-to-low transition starts a frame, so a held break never retriggers.
  assign fall = rxs_prev_q & ~rxs_q;

  // Receiver state, bit timing and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // Receiver next-state: half-bit wait to centre on the start bit, then full-bit steps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d     = '0;
          bit_d     = '0;
          par_bad_d = 1'b0;
          state_d   = rxs_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = StStop;
          // Even parity: the parity bit equals the XOR of the data bits.
          if (rxs_q != ^shift_q) begin
            par_bad_d = 1'b1;
            par_set   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rxs_q) push_req  = ~par_bad_q;
          else       frame_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign full     = (count_q == OccFull);
  assign pop      = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_ok  = push_req & (~full | pop);
  assign over_set = push_req & full & ~pop;

  // Occupancy next-state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
  end

  // FIFO storage, pointers (natural power-of-two wrap) and the accept pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      new_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      new_q   <= push_ok;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= (frame_err_q & ~err_clr) | frame_set;
      overrun_q    <= (overrun_q & ~err_clr) | over_set;
      parity_err_q <= (parity_err_q & ~err_clr) | par_set;
    end
  end

  assign rx_valid  = (count_q != '0);
  assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign isNewData = new_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  logic unused_par;
  assign unused_par = parity_err_q ^ par_bad_q ^ par_set;
`endif

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Self-checking bench for uart_rx_byte_fifo: random bytes through a queue-based model.
module tb_uart_rx_byte_fifo;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif
  // Line change to stop-bit sample: 2 sync flops + edge detect, half bit, then NBits-1 bits.
  localparam int PushLat = 3 + CPB / 2 + (NBits - 1) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       isNewData;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       err_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_byte_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RxD      (RxD),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .isNewData(isNewData),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int new_cnt = 0;

  logic [7:0] exp_q[$];
  logic       m_frame = 1'b0;
  logic       m_over = 1'b0;

  always @(negedge clk) if (isNewData === 1'b1) new_cnt++;

  // Drive one frame starting at the current negedge, then a short idle gap.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RxD = ^d;
    repeat (CPB) @(negedge clk);
`endif
    RxD = stop_ok;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Reference: what a finished frame does to the buffered contents and flags.
  task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic pop_same);
    logic [7:0] tmp;
    if (!stop_ok) m_frame = 1'b1;
    else begin
      if (pop_same && exp_q.size() > 0) tmp = exp_q.pop_front();
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else m_over = 1'b1;
    end
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_frame = 1'b0;
    m_over  = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain_and_check(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rx_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_valid: got %b want 1", tag, rx_valid);
      end
      n_cmp++;
      if (rx_data !== e) begin
        n_fail++;
        $display("FAIL %s_data: got %h want %h", tag, rx_data, e);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_empty: got rx_valid=%b want 0", tag, rx_valid);
    end
  endtask

  task automatic check_flags(input string tag);
    n_cmp++;
    if (frame_err !== m_frame) begin
      n_fail++;
      $display("FAIL %s_frame_err: got %b want %b", tag, frame_err, m_frame);
    end
    n_cmp++;
    if (overrun !== m_over) begin
      n_fail++;
      $display("FAIL %s_overrun: got %b want %b", tag, overrun, m_over);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if ({rx_data, rx_valid, isNewData, busy, frame_err, overrun} !== 13'h0) begin
      n_fail++;
      $display("FAIL %s: got data=%h v=%b nd=%b busy=%b fe=%b ov=%b want all 0", tag,
               rx_data, rx_valid, isNewData, busy, frame_err, overrun);
    end
`ifdef UART_RX_PARITY_EN
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_parity_err: got %b want 0", tag, parity_err);
    end
`endif
  endtask

  task automatic test_reset();
    #2;
    check_idle_outputs("reset_hold");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_release");
  endtask

  task automatic test_single();
    int base = new_cnt;
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    n_cmp++;
    if (new_cnt !== base + 1) begin
      n_fail++;
      $display("FAIL single_newdata: got %0d pulses want 1", new_cnt - base);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_hold: got %h want a5", rx_data);
    end
    drain_and_check("single");
    check_flags("single");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, DEPTH);
      int base = new_cnt;
      int acc = 0;
      for (int k = 0; k < n; k++) begin
        logic [7:0] d = 8'($urandom);
        logic       s = ($urandom_range(0, 4) != 0);
        if (s) acc++;
        send_frame(d, s);
        model_frame(d, s, 1'b0);
      end
      n_cmp++;
      if (new_cnt !== base + acc) begin
        n_fail++;
        $display("FAIL random_newdata: got %0d pulses want %0d", new_cnt - base, acc);
      end
      check_flags("random");
      drain_and_check("random");
      clear_errors();
      check_flags("random_clr");
    end
  endtask

  task automatic test_overrun();
    int base = new_cnt;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1);
      model_frame(8'(k), 1'b1, 1'b0);
    end
    n_cmp++;
    if (new_cnt !== base + DEPTH) begin
      n_fail++;
      $display("FAIL overrun_newdata: got %0d pulses want %0d", new_cnt - base, DEPTH);
    end
    check_flags("overrun");
    drain_and_check("overrun");
    clear_errors();
    check_flags("overrun_clr");
  endtask

  task automatic test_frame_err();
    int base = new_cnt;
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    check_flags("frame");
    n_cmp++;
    if (rx_valid !== 1'b0 || new_cnt !== base) begin
      n_fail++;
      $display("FAIL frame_nodata: got valid=%b pulses=%0d want 0 0", rx_valid, new_cnt - base);
    end
    clear_errors();
    check_flags("frame_clr");
  endtask

  task automatic test_glitch();
    int base = new_cnt;
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start: got busy=%b want 1", busy);
    end
    RxD = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || new_cnt !== base) begin
      n_fail++;
      $display("FAIL glitch_idle: got busy=%b valid=%b pulses=%0d want 0 0 0", busy, rx_valid,
               new_cnt - base);
    end
    check_flags("glitch");
  endtask

  task automatic test_full_pop();
    int base;
    logic [7:0] nb = 8'($urandom);
    for (int k = 0; k < DEPTH; k++) begin
      logic [7:0] d = 8'($urandom);
      send_frame(d, 1'b1);
      model_frame(d, 1'b1, 1'b0);
    end
    base = new_cnt;
    fork
      send_frame(nb, 1'b1);
      begin
        repeat (PushLat - 1) @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    model_frame(nb, 1'b1, 1'b1);
    n_cmp++;
    if (new_cnt !== base + 1) begin
      n_fail++;
      $display("FAIL fullpop_newdata: got %0d pulses want 1", new_cnt - base);
    end
    check_flags("fullpop");
    drain_and_check("fullpop");
  endtask

  task automatic test_reset_mid();
    int base;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] d = 8'($urandom);
      send_frame(d, 1'b1);
      model_frame(d, 1'b1, 1'b0);
    end
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (60) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_idle_outputs("reset_mid");
      end
    join
    exp_q.delete();
    m_frame = 1'b0;
    m_over  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    base = new_cnt;
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    n_cmp++;
    if (new_cnt !== base + 1) begin
      n_fail++;
      $display("FAIL after_reset_newdata: got %0d pulses want 1", new_cnt - base);
    end
    drain_and_check("after_reset");
    check_flags("after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
